// File: rtl/clock_time_controller.sv
// 12-hour clock with a RUN / SET_HOUR / SET_MIN mode machine driven by two
// pre-conditioned push buttons and a prescaler producing a one-second tick.
module clock_time_controller #(
    parameter int TICK_DIV = 1000
) (
    input  logic       CLK,
    input  logic       RST,
    input  logic       BTN_MODE,
    input  logic       BTN_INC,
    output logic [3:0] CNT12,
    output logic [5:0] CNT_MIN,
    output logic [5:0] CNT_SEC,
    output logic       PM,
    output logic [1:0] MODE,
    output logic       SEC_TICK
);

    localparam int PW = (TICK_DIV > 2) ? $clog2(TICK_DIV) : 1;
    localparam logic [PW-1:0] PRESC_LAST = PW'(TICK_DIV - 1);

    typedef enum logic [1:0] {
        RUN      = 2'b00,
        SET_HOUR = 2'b01,
        SET_MIN  = 2'b10,
        ILLEGAL  = 2'b11
    } state_t;

    state_t        state;
    state_t        state_next;
    logic [PW-1:0] presc;
    logic          mode_prev;
    logic          inc_prev;
    logic          mode_edge;
    logic          inc_edge;
    logic          tick;
    logic          presc_run;
    logic          presc_clr;
    logic          sec_clr;
    logic          inc_hour;
    logic          inc_min;
    logic          sec_carry;
    logic          min_step;
    logic          hour_step;

    assign mode_edge = BTN_MODE & ~mode_prev;
    assign inc_edge  = BTN_INC & ~inc_prev;
    assign MODE      = state;

    always_ff @(posedge CLK) begin
        if (RST) begin
            state <= RUN;
        end else begin
            state <= state_next;
        end
    end

    // A mode edge always wins over an increment edge or a tick in the same cycle.
    always_comb begin
        state_next = state;
        tick       = 1'b0;
        presc_run  = 1'b0;
        presc_clr  = 1'b0;
        sec_clr    = 1'b0;
        inc_hour   = 1'b0;
        inc_min    = 1'b0;
        case (state)
            RUN: begin
                if (mode_edge) begin
                    state_next = SET_HOUR;
                    presc_clr  = 1'b1;
                    sec_clr    = 1'b1;
                end else begin
                    presc_run = 1'b1;
                    tick      = (presc == PRESC_LAST);
                end
            end
            SET_HOUR: begin
                if (mode_edge) begin
                    state_next = SET_MIN;
                end else begin
                    inc_hour = inc_edge;
                end
            end
            SET_MIN: begin
                if (mode_edge) begin
                    state_next = RUN;
                    presc_clr  = 1'b1;
                end else begin
                    inc_min = inc_edge;
                end
            end
            default: begin
                state_next = RUN;
            end
        endcase
    end

    assign sec_carry = tick && (CNT_SEC == 6'd59);
    assign min_step  = sec_carry || inc_min;
    assign hour_step = (sec_carry && (CNT_MIN == 6'd59)) || inc_hour;

    always_ff @(posedge CLK) begin
        if (RST) begin
            mode_prev <= 1'b0;
            inc_prev  <= 1'b0;
            presc     <= '0;
            SEC_TICK  <= 1'b0;
            CNT_SEC   <= 6'd0;
            CNT_MIN   <= 6'd0;
            CNT12     <= 4'd0;
            PM        <= 1'b0;
        end else begin
            mode_prev <= BTN_MODE;
            inc_prev  <= BTN_INC;
            SEC_TICK  <= tick;

            if (presc_clr) begin
                presc <= '0;
            end else if (presc_run) begin
                presc <= tick ? '0 : presc + 1'b1;
            end

            if (sec_clr) begin
                CNT_SEC <= 6'd0;
            end else if (tick) begin
                CNT_SEC <= (CNT_SEC >= 6'd59) ? 6'd0 : CNT_SEC + 6'd1;
            end

            // Minute wrap from a SET_MIN increment does not feed hour_step.
            if (min_step) begin
                CNT_MIN <= (CNT_MIN >= 6'd59) ? 6'd0 : CNT_MIN + 6'd1;
            end

            if (hour_step) begin
                if (CNT12 >= 4'd11) begin
                    CNT12 <= 4'd0;
                    PM    <= ~PM;
                end else begin
                    CNT12 <= CNT12 + 4'd1;
                end
            end
        end
    end

endmodule

// File: tb/tb_clock_time_controller.sv
// Directed bench for clock_time_controller at TICK_DIV=4: reset, ticking,
// rollover at 11:59:59 AM, set modes, button edge handling and reset priority.
module tb_clock_time_controller;

    logic       CLK;
    logic       RST;
    logic       BTN_MODE;
    logic       BTN_INC;
    logic [3:0] CNT12;
    logic [5:0] CNT_MIN;
    logic [5:0] CNT_SEC;
    logic       PM;
    logic [1:0] MODE;
    logic       SEC_TICK;

    int n_vec  = 0;
    int n_fail = 0;
    int tick_seen;

    clock_time_controller #(.TICK_DIV(4)) dut (
        .CLK      (CLK),
        .RST      (RST),
        .BTN_MODE (BTN_MODE),
        .BTN_INC  (BTN_INC),
        .CNT12    (CNT12),
        .CNT_MIN  (CNT_MIN),
        .CNT_SEC  (CNT_SEC),
        .PM       (PM),
        .MODE     (MODE),
        .SEC_TICK (SEC_TICK)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    task automatic step(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge CLK);
            #1;
        end
    endtask

    task automatic chk(input string tag, input int got, input int exp);
        n_vec++;
        assert (got === exp)
        else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic press_inc(input int n);
        for (int i = 0; i < n; i++) begin
            BTN_INC = 1'b1;
            step(1);
            BTN_INC = 1'b0;
            step(1);
        end
    endtask

    task automatic press_mode();
        BTN_MODE = 1'b1;
        step(1);
        BTN_MODE = 1'b0;
        step(1);
    endtask

    task automatic chk_time(input string tag, input int h, input int m, input int s, input int pm);
        chk({tag, "_hour"}, CNT12, h);
        chk({tag, "_min"}, CNT_MIN, m);
        chk({tag, "_sec"}, CNT_SEC, s);
        chk({tag, "_pm"}, PM, pm);
    endtask

    initial begin
        RST      = 1'b1;
        BTN_MODE = 1'b0;
        BTN_INC  = 1'b0;
        step(2);
        chk_time("reset", 0, 0, 0, 0);
        chk("reset_mode", MODE, 0);
        chk("reset_tick", SEC_TICK, 0);

        // First tick four cycles after reset release.
        RST = 1'b0;
        step(3);
        chk("pre_tick", SEC_TICK, 0);
        chk("pre_tick_sec", CNT_SEC, 0);
        step(1);
        chk("first_tick", SEC_TICK, 1);
        chk_time("first_tick", 0, 0, 1, 0);
        step(1);
        chk("tick_one_cycle", SEC_TICK, 0);

        // Advance to SEC=37, then enter SET_HOUR.
        step(3 + 35 * 4);
        chk("sec37_tick", SEC_TICK, 1);
        chk("sec37", CNT_SEC, 37);
        BTN_MODE = 1'b1;
        step(1);
        chk("enter_sethour_mode", MODE, 1);
        chk("enter_sethour_sec", CNT_SEC, 0);
        BTN_MODE = 1'b0;
        tick_seen = 0;
        for (int i = 0; i < 20; i++) begin
            step(1);
            if (SEC_TICK) tick_seen++;
        end
        chk("frozen_no_tick", tick_seen, 0);
        chk_time("frozen", 0, 0, 0, 0);
        chk("frozen_mode", MODE, 1);

        // SET_HOUR: wrap 11 AM -> 0 PM, held button increments once.
        press_inc(11);
        chk_time("hour11", 11, 0, 0, 0);
        BTN_INC = 1'b1;
        step(1);
        chk_time("hour_wrap", 0, 0, 0, 1);
        step(10);
        chk_time("hour_held", 0, 0, 0, 1);
        BTN_INC = 1'b0;
        step(1);
        press_inc(23);
        chk_time("hour11am", 11, 0, 0, 0);

        // SET_MIN: wrap without hour carry.
        press_mode();
        chk("setmin_mode", MODE, 2);
        press_inc(59);
        chk("min59", CNT_MIN, 59);
        press_inc(1);
        chk_time("min_wrap", 11, 0, 0, 0);
        press_inc(59);
        chk("min59_again", CNT_MIN, 59);

        // Simultaneous edges: mode change only, prescaler restarts.
        BTN_MODE = 1'b1;
        BTN_INC  = 1'b1;
        step(1);
        chk("simul_mode", MODE, 0);
        chk("simul_min", CNT_MIN, 59);
        BTN_MODE = 1'b0;
        BTN_INC  = 1'b0;
        step(3);
        chk("restart_no_tick", SEC_TICK, 0);
        step(1);
        chk("restart_tick", SEC_TICK, 1);
        chk_time("restart", 11, 59, 1, 0);

        // Run up to 11:59:59 AM, then roll over to 12:00:00 PM.
        step(58 * 4);
        chk_time("before_roll", 11, 59, 59, 0);
        step(4);
        chk("roll_tick", SEC_TICK, 1);
        chk_time("rollover", 0, 0, 0, 1);

        // Ignore increments in RUN.
        press_inc(3);
        chk("run_inc_ignored", CNT_MIN, 0);

        // Reset from SET_MIN with both buttons pressed.
        press_mode();
        press_mode();
        press_inc(3);
        chk("pre_reset_min", CNT_MIN, 3);
        chk("pre_reset_mode", MODE, 2);
        RST      = 1'b1;
        BTN_MODE = 1'b1;
        BTN_INC  = 1'b1;
        step(1);
        chk_time("mid_set_reset", 0, 0, 0, 0);
        chk("mid_set_reset_mode", MODE, 0);
        chk("mid_set_reset_tick", SEC_TICK, 0);

        // Mode button held through reset release registers one edge.
        RST     = 1'b0;
        BTN_INC = 1'b0;
        step(1);
        chk("held_mode_edge", MODE, 1);
        step(3);
        chk("held_mode_once", MODE, 1);
        BTN_MODE = 1'b0;
        step(1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule

// File: doc/clock_time_controller.md
CLOCK_TIME_CONTROLLER -- requirements
Module: clock_time_controller

Interface
REQ-001 SHALL have parameter TICK_DIV, default 1000, meaning CLK cycles per one-second tick (legal range >= 2).
REQ-002 SHALL have port CLK, input, 1, the single clock; all state changes on its rising edge.
REQ-003 SHALL have port RST, input, 1, synchronous active-high reset, sampled on the CLK rising edge.
REQ-004 SHALL have port BTN_MODE, input, 1, mode button level; already synchronized and debounced.
REQ-005 SHALL have port BTN_INC, input, 1, increment button level; already synchronized and debounced.
REQ-006 SHALL have port CNT12, output, 4, hour count 0..11, where 0 means hour 12; drives the hour decoder.
REQ-007 SHALL have port CNT_MIN, output, 6, minute count 0..59.
REQ-008 SHALL have port CNT_SEC, output, 6, second count 0..59.
REQ-009 SHALL have port PM, output, 1, 0 = AM, 1 = PM.
REQ-010 SHALL have port MODE, output, 2, current state: 00 RUN, 01 SET_HOUR, 10 SET_MIN.
REQ-011 SHALL have port SEC_TICK, output, 1, one-cycle pulse in the cycle the seconds counter advances.

Function
REQ-012 SHALL detect button presses as rising edges: an edge is level=1 in this cycle with the registered previous level=0; a held button yields one edge only.
REQ-013 SHALL implement FSM RUN -> SET_HOUR -> SET_MIN -> RUN, advancing one state per BTN_MODE edge.
REQ-014 SHALL in RUN count a prescaler 0..TICK_DIV-1; when it reaches TICK_DIV-1 it wraps to 0 and the tick fires in that cycle.
REQ-015 SHALL on a RUN tick increment CNT_SEC and assert SEC_TICK for exactly that cycle; outputs update on the same edge the tick is registered.
REQ-016 SHALL wrap CNT_SEC 59->0 with a carry that increments CNT_MIN in the same cycle.
REQ-017 SHALL wrap CNT_MIN 59->0 with a carry that increments CNT12 in the same cycle.
REQ-018 SHALL wrap CNT12 11->0 on a carry or on a SET_HOUR increment, and PM SHALL toggle in that same cycle (11:59:59 AM -> 12:00:00 PM).
REQ-019 SHALL never drive CNT12 above 11, or CNT_MIN or CNT_SEC above 59.
REQ-020 SHALL on the transition RUN->SET_HOUR clear CNT_SEC and the prescaler to 0; time SHALL then be frozen in both SET states and SEC_TICK SHALL stay 0.
REQ-021 SHALL in SET_HOUR increment CNT12 by 1 per BTN_INC edge, wrapping per REQ-018.
REQ-022 SHALL in SET_MIN increment CNT_MIN by 1 per BTN_INC edge, wrapping 59->0 with no carry into CNT12.
REQ-023 SHALL ignore BTN_INC edges in RUN.
REQ-024 SHALL, when BTN_MODE and BTN_INC edges occur in the same cycle, act on the mode change only and discard the increment.
REQ-025 SHALL on the transition SET_MIN->RUN restart the prescaler from 0, so the first tick comes TICK_DIV cycles later.
REQ-026 SHALL treat MODE encoding 11 as unreachable; if it is ever entered, the FSM returns to RUN on the next cycle.

Reset
REQ-027 SHALL on RST=1 at a clock edge set CNT12=0, CNT_MIN=0, CNT_SEC=0, PM=0, MODE=00, SEC_TICK=0, prescaler=0, and both previous-button registers to 0.
REQ-028 SHALL give reset priority over all ticks and button edges in the same cycle, including mid-set-mode.
REQ-029 SHALL, if a button is held high through the release of RST, register it as one edge on the first cycle after reset.

Verification (TICK_DIV=4)
REQ-030 Reset release, run 4 cycles -> SEC_TICK pulses once on the 4th cycle; CNT_SEC=1; CNT12=0, PM=0.
REQ-031 Force the time to 11:59:59 AM (CNT12=11, MIN=59, SEC=59, PM=0), then one tick -> CNT12=0, CNT_MIN=0, CNT_SEC=0, PM=1, all in the same cycle.
REQ-032 From RUN with SEC=37, BTN_MODE edge -> MODE=01, CNT_SEC=0; then 20 idle cycles -> no SEC_TICK, time unchanged.
REQ-033 In SET_HOUR with CNT12=11, PM=0, one BTN_INC edge -> CNT12=0, PM=1; hold BTN_INC high 10 cycles -> only one increment.
REQ-034 In SET_MIN with MIN=59, BTN_INC edge -> MIN=0, CNT12 unchanged; simultaneous MODE+INC edges -> MODE=00, MIN unchanged.
REQ-035 In SET_MIN, assert RST -> all outputs at reset values on the next edge and MODE=00.
